logic_result_stage: RTL

- Registered output stage directly downstream of the 16-bit bitwise logic unit (AND/OR/XOR/XNOR) in the ALU datapath.
- Captures the logic result and its opcode, derives status flags, and presents them to the writeback/flags register with a valid/ready handshake.
- Contains a 2-entry skid buffer so writeback stalls never drop a result.
- Keeps a saturating count of equality hits, where equality is an XNOR result of all ones.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/skid_buffer2.sv | 71 +++++++
 rtl/logic_result_stage.sv | 78 +++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic opcodes, per-result status flags and default width.
// The flag struct gains a parity bit when LOGIC_RESULT_PARITY_EN is defined.
package alu_pkg;

  localparam int unsigned LOGIC_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_XNOR = 2'd3
  } logic_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic eq;
`ifdef LOGIC_RESULT_PARITY_EN
    logic p;
`endif
  } flags_t;

endpackage

// File: rtl/skid_buffer2.sv
// Generic 2-entry valid/ready buffer with registered in_ready.
// The output register is the head entry, and skid_q holds the second entry.
module skid_buffer2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload
);

  typedef enum logic [1:0] {EMPTY, FULL1, FULL2} occ_e;

  occ_e         state;
  logic [W-1:0] skid_q;
  logic         in_xfer;
  logic         out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      skid_q      <= '0;
      out_payload <= '0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            out_payload <= in_payload;
            out_valid   <= 1'b1;
            state       <= FULL1;
          end
        end
        FULL1: begin
          if (in_xfer && out_xfer) begin
            out_payload <= in_payload;
          end else if (in_xfer) begin
            skid_q   <= in_payload;
            in_ready <= 1'b0;
            state    <= FULL2;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL2: begin
          // in_ready is low here, so only the output side can move
          if (out_xfer) begin
            out_payload <= skid_q;
            in_ready    <= 1'b1;
            state       <= FULL1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/logic_result_stage.sv
// Registered output stage for the logic unit: flags, 2-entry skid buffer, eq-hit counter.
// Optional LOGIC_RESULT_PARITY_EN adds out_p (even parity of out_data).
module logic_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = LOGIC_WIDTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_op,
  output logic             out_z,
  output logic             out_n,
  output logic             out_eq,
`ifdef LOGIC_RESULT_PARITY_EN
  output logic             out_p,
`endif
  output logic [CNT_W-1:0] eq_count,
  input  logic             clr_count
);

  localparam int unsigned PW = WIDTH + 2 + $bits(flags_t);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  flags_t         in_flags;
  flags_t         out_flags;
  logic [PW-1:0]  in_payload;
  logic [PW-1:0]  out_payload;

  always_comb begin
    in_flags    = '0;
    in_flags.z  = (in_data == '0);
    in_flags.n  = in_data[WIDTH-1];
    in_flags.eq = (logic_op_e'(in_op) == OP_XNOR) && (&in_data);
`ifdef LOGIC_RESULT_PARITY_EN
    in_flags.p  = ^in_data;
`endif
  end

  assign in_payload = {in_data, in_op, in_flags};

  skid_buffer2 #(.W(PW)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload)
  );

  assign {out_data, out_op, out_flags} = out_payload;
  assign out_z  = out_flags.z;
  assign out_n  = out_flags.n;
  assign out_eq = out_flags.eq;
`ifdef LOGIC_RESULT_PARITY_EN
  assign out_p  = out_flags.p;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eq_count <= '0;
    end else if (clr_count) begin
      eq_count <= '0;
    end else if (out_valid && out_ready && out_eq && (eq_count != CNT_MAX)) begin
      eq_count <= eq_count + CNT_W'(1);
    end
  end

endmodule
